// File: rtl/ped_xing_pkg.sv
// Shared state encoding, default timing constants and a width helper for the
// pedestrian-crossing controller.
package ped_xing_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        WALK  = 2'b01,
        CLEAR = 2'b10
    } ped_state_e;

    localparam int DEF_SEC_CYC    = 1000;
    localparam int DEF_WALK_S     = 4;
    localparam int DEF_CLR_S      = 3;
    localparam int DEF_FLASH_HALF = 500;
    localparam int DEF_DEB_CYC    = 200;
    localparam int DEF_CNT_W      = 4;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ped_btn_cond.sv
// Push-button conditioning: 2-flop synchroniser, optional debounce
// (PED_DEBOUNCE_EN), then rising-edge detect producing a 1-cycle btn_evt.
module ped_btn_cond
    import ped_xing_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_btn,
    output logic btn_evt
);

    logic sync1_q;
    logic sync2_q;
    logic lvl;
    logic lvl_dly_q;

`ifdef PED_DEBOUNCE_EN
    localparam int DW = cnt_width(DEB_CYC);

    logic          deb_lvl_q;
    logic          deb_lvl_d;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;

    // The level only follows the synchronised input after DEB_CYC
    // consecutive cycles of disagreement; any agreeing cycle restarts the run.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign lvl = deb_lvl_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync1_q   <= ped_btn;
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl;
        end
    end

    assign btn_evt = lvl & ~lvl_dly_q;

endmodule

// File: rtl/ped_xing_ctrl.sv
// Pedestrian-crossing stage behind the vehicle light FSM: WALK on pure red,
// flashing CLEAR with seconds countdown, sticky fault. Option: PED_DEBOUNCE_EN.
module ped_xing_ctrl
    import ped_xing_pkg::*;
#(
    parameter int SEC_CYC    = DEF_SEC_CYC,
    parameter int WALK_S     = DEF_WALK_S,
    parameter int CLR_S      = DEF_CLR_S,
    parameter int FLASH_HALF = DEF_FLASH_HALF,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red_light,
    input  logic             yellow_light,
    input  logic             green_light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam int PH_MAX = ((WALK_S > CLR_S) ? WALK_S : CLR_S) * SEC_CYC - 1;
    localparam int PH_W   = cnt_width(PH_MAX);
    localparam int SEC_W  = cnt_width(SEC_CYC - 1);
    localparam int FL_W   = cnt_width(FLASH_HALF - 1);

    ped_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [FL_W-1:0]  flash_q, flash_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] countdown_q, countdown_d;
    logic             fault_q, fault_d;
    logic             pr_d_q, pr_d_d;

    logic btn_evt;
    logic pr;
    logic pr_rise;
    logic illegal;

    ped_btn_cond #(
        .DEB_CYC (DEB_CYC)
    ) u_btn (
        .clk     (clk),
        .reset   (reset),
        .ped_btn (ped_btn),
        .btn_evt (btn_evt)
    );

    assign pr      = red_light & ~yellow_light & ~green_light;
    assign pr_rise = pr & ~pr_d_q;
    assign illegal = (green_light & (red_light | yellow_light)) |
                     ~(red_light | yellow_light | green_light);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sec_d       = sec_q;
        flash_d     = flash_q;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        countdown_d = countdown_q;
        req_d       = req_q | btn_evt;
        fault_d     = fault_q | illegal;
        pr_d_d      = pr;

        unique case (state_q)
            STOP: begin
                // A button edge coinciding with pr_rise is served immediately.
                if (pr_rise && (req_q || btn_evt) && !fault_q) begin
                    state_d     = WALK;
                    req_d       = 1'b0;
                    walk_d      = 1'b1;
                    dont_walk_d = 1'b0;
                    phase_d     = '0;
                end
            end
            WALK: begin
                if (!pr || fault_q) begin
                    state_d = STOP;
                end else if (phase_q == PH_W'(WALK_S * SEC_CYC - 1)) begin
                    state_d     = CLEAR;
                    phase_d     = '0;
                    sec_d       = '0;
                    flash_d     = '0;
                    walk_d      = 1'b0;
                    dont_walk_d = 1'b1;
                    countdown_d = CNT_W'(CLR_S);
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            CLEAR: begin
                if (!pr || fault_q || (phase_q == PH_W'(CLR_S * SEC_CYC - 1))) begin
                    state_d = STOP;
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (sec_q == SEC_W'(SEC_CYC - 1)) begin
                        sec_d       = '0;
                        countdown_d = countdown_q - 1'b1;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                    if (flash_q == FL_W'(FLASH_HALF - 1)) begin
                        flash_d     = '0;
                        dont_walk_d = ~dont_walk_q;
                    end else begin
                        flash_d = flash_q + 1'b1;
                    end
                end
            end
            default: state_d = STOP;
        endcase

        // Every way into STOP (timeout, abort, fault) lands on the same outputs.
        if (state_d == STOP && state_q != STOP) begin
            phase_d     = '0;
            sec_d       = '0;
            flash_d     = '0;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            countdown_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STOP;
            phase_q     <= '0;
            sec_q       <= '0;
            flash_q     <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            req_q       <= 1'b0;
            countdown_q <= '0;
            fault_q     <= 1'b0;
            pr_d_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sec_q       <= sec_d;
            flash_q     <= flash_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            req_q       <= req_d;
            countdown_q <= countdown_d;
            fault_q     <= fault_d;
            pr_d_q      <= pr_d_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_q;
    assign countdown   = countdown_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Bench for ped_xing_ctrl: per-cycle reference model feeding an expected
// queue, a negedge monitor that pops and compares, plus directed scenario checks.
module tb_ped_xing_ctrl;

    localparam int SEC_CYC    = 10;
    localparam int WALK_S     = 4;
    localparam int CLR_S      = 3;
    localparam int FLASH_HALF = 5;
    localparam int DEB_CYC    = 3;
    localparam int CNT_W      = 4;
    localparam int EW         = CNT_W + 4;

    logic             clk;
    logic             reset;
    logic             red_light;
    logic             yellow_light;
    logic             green_light;
    logic             ped_btn;
    logic             walk;
    logic             dont_walk;
    logic             req_pending;
    logic [CNT_W-1:0] countdown;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_btn = 0;

    logic [EW-1:0] exp_q[$];

    ped_xing_ctrl #(
        .SEC_CYC    (SEC_CYC),
        .WALK_S     (WALK_S),
        .CLR_S      (CLR_S),
        .FLASH_HALF (FLASH_HALF),
        .DEB_CYC    (DEB_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .red_light    (red_light),
        .yellow_light (yellow_light),
        .green_light  (green_light),
        .ped_btn      (ped_btn),
        .walk         (walk),
        .dont_walk    (dont_walk),
        .req_pending  (req_pending),
        .countdown    (countdown),
        .fault        (fault)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 = don't walk, 1 = walk, 2 = clearance. m_t = cycles spent in mode.
    int m_mode = 0;
    int m_t    = 0;
    bit m_req  = 0;
    bit m_flt  = 0;
    bit m_prev_pr = 0;
    bit hist[8];       // hist[k] = button sampled k+1 edges ago
    bit lvl_a = 0;
    bit lvl_b = 0;

    always @(posedge clk) begin
        bit evt, pr, rise, ill, e_walk, e_dw;
        int e_cd;
`ifdef PED_DEBOUNCE_EN
        bit stable;
`endif
        if (reset) begin
            m_mode = 0; m_t = 0; m_req = 0; m_flt = 0; m_prev_pr = 0;
            lvl_a = 0; lvl_b = 0;
            for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        end else begin
`ifdef PED_DEBOUNCE_EN
            stable = 1'b1;
            for (int i = 1; i <= DEB_CYC; i++) if (hist[i] == lvl_a) stable = 1'b0;
            evt   = lvl_a & ~lvl_b;
            lvl_b = lvl_a;
            if (stable) lvl_a = hist[1];
`else
            evt = hist[1] & ~hist[2];
`endif
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ped_btn;

            pr   = red_light & ~yellow_light & ~green_light;
            rise = pr & ~m_prev_pr;
            m_prev_pr = pr;
            ill  = (green_light & (red_light | yellow_light)) |
                   ~(red_light | yellow_light | green_light);

            if (m_mode == 0) begin
                if (rise && (m_req || evt) && !m_flt) begin
                    m_mode = 1; m_t = 0; m_req = 0;
                end else if (evt) begin
                    m_req = 1;
                end
            end else begin
                if (evt) m_req = 1;
                if (!pr || m_flt) begin
                    m_mode = 0;
                end else begin
                    m_t++;
                    if (m_mode == 1 && m_t == WALK_S * SEC_CYC) begin
                        m_mode = 2; m_t = 0;
                    end else if (m_mode == 2 && m_t == CLR_S * SEC_CYC) begin
                        m_mode = 0;
                    end
                end
            end
            if (ill) m_flt = 1;
        end
        e_walk = (m_mode == 1);
        e_dw   = (m_mode == 0) ? 1'b1 :
                 (m_mode == 1) ? 1'b0 : (((m_t / FLASH_HALF) % 2) == 0);
        e_cd   = (m_mode == 2) ? CLR_S - m_t / SEC_CYC : 0;
        exp_q.push_back({e_walk, e_dw, m_req, m_flt, CNT_W'(e_cd)});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_walk",        int'(walk),        int'(e[EW-1]));
            check("sb_dont_walk",   int'(dont_walk),   int'(e[EW-2]));
            check("sb_req_pending", int'(req_pending), int'(e[EW-3]));
            check("sb_fault",       int'(fault),       int'(e[EW-4]));
            check("sb_countdown",   int'(countdown),   int'(e[CNT_W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_btn && $urandom_range(0, 39) == 0) ped_btn = ~ped_btn;
        end
    endtask

    task automatic set_lights(input bit r, input bit y, input bit g);
        red_light    = r;
        yellow_light = y;
        green_light  = g;
    endtask

    task automatic press(input int n);
        ped_btn = 1'b1;
        cycles(n);
        ped_btn = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        cycles(n);
        reset = 1'b0;
    endtask

    // Request during green, then yellow, then red; waits for WALK to appear.
    task automatic request_then_red(output bit seen);
        int waited;
        set_lights(0, 0, 1);
        cycles(5);
        press(3);
        cycles(6);
        set_lights(0, 1, 0);
        cycles(5);
        set_lights(1, 0, 0);
        waited = 0;
        while (!walk && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        seen = walk;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        int n, wcnt;
        reset   = 1'b1;
        ped_btn = 1'b0;
        set_lights(0, 0, 1);
        cycles(3);
        reset = 1'b0;
        cycles(1);
        check("reset_walk", walk, 0);
        check("reset_dont_walk", dont_walk, 1);
        check("reset_countdown", countdown, 0);

        // Full service: press in green, WALK 40 cycles, CLEAR 30 with 3,2,1.
        set_lights(0, 0, 1);
        cycles(5);
        press(4);
        cycles(5);
        check("req_before_red", req_pending, 1);
        request_then_red(seen);
        check("walk_start", walk, 1);
        check("req_cleared_on_walk", req_pending, 0);
        n = 0;
        while (walk && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("walk_len", n, WALK_S * SEC_CYC);
        for (int i = 0; i <= CLR_S * SEC_CYC; i++) begin
            check("clr_countdown", countdown, (i < CLR_S * SEC_CYC) ? CLR_S - i / SEC_CYC : 0);
            check("clr_dont_walk", dont_walk, (i < CLR_S * SEC_CYC) ? int'(((i / FLASH_HALF) % 2) == 0) : 1);
            check("clr_walk", walk, 0);
            @(negedge clk);
        end
        cycles(10);

        // Abort: yellow at WALK cycle 12.
        request_then_red(seen);
        check("abort_walk_seen", seen, 1);
        cycles(12);
        set_lights(0, 1, 0);
        cycles(1);
        check("abort_walk", walk, 0);
        check("abort_dont_walk", dont_walk, 1);
        check("abort_countdown", countdown, 0);
        cycles(5);

        // Press during WALK: kept, served only at the next red phase.
        request_then_red(seen);
        cycles(10);
        press(3);
        cycles(100);
        check("midwalk_req_kept", req_pending, 1);
        check("midwalk_no_rewalk", walk, 0);
        set_lights(0, 0, 1);
        cycles(10);
        set_lights(0, 1, 0);
        cycles(5);
        set_lights(1, 0, 0);
        n = 0;
        while (!walk && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("next_red_walk", walk, 1);
        check("next_red_req_clr", req_pending, 0);
        cycles(80);

        // Reset in the middle of WALK.
        request_then_red(seen);
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("rst_mid_walk", walk, 0);
        check("rst_mid_dont_walk", dont_walk, 1);
        cycles(5);

        // Short glitch versus a real press.
        set_lights(0, 0, 1);
        cycles(5);
        press(2);
        cycles(10);
`ifdef PED_DEBOUNCE_EN
        check("glitch_req", req_pending, 0);
`else
        check("glitch_req", req_pending, 1);
`endif
        apply_reset(2);
        press(5);
        cycles(10);
        check("press5_req", req_pending, 1);

        // Illegal lights: sticky fault, no WALK, requests still latched.
        set_lights(1, 0, 1);
        cycles(1);
        set_lights(0, 0, 1);
        cycles(3);
        check("fault_set", fault, 1);
        press(3);
        cycles(5);
        set_lights(0, 1, 0);
        cycles(5);
        set_lights(1, 0, 0);
        wcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (walk) wcnt++;
        end
        check("fault_no_walk", wcnt, 0);
        check("fault_req_latched", req_pending, 1);
        check("fault_dont_walk", dont_walk, 1);
        apply_reset(2);
        check("fault_cleared", fault, 0);
        check("fault_req_cleared", req_pending, 0);

        // Randomised light cycles with random button activity.
        rand_btn = 1'b1;
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 14) == 0) apply_reset(1);
            set_lights(0, 0, 1);
            cycles($urandom_range(5, 40));
            set_lights(0, 1, 0);
            cycles($urandom_range(2, 8));
            set_lights(1, 0, 0);
            cycles($urandom_range(20, 110));
        end
        rand_btn = 1'b0;
        ped_btn  = 1'b0;
        cycles(10);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
